// File: rtl/asic_iocorner_poc.sv
// Power-on-control sequencer for an IO ring corner.
// Synchronises the IO and core supply-good flags, debounces them, then
// releases POC to each ring segment in ascending order with a programmable
// stagger. A supply loss re-asserts every POC at once and bumps a saturating
// fault counter. A software force drops the ring back to safe without
// counting a fault.
module asic_iocorner_poc #(
   parameter int NSEG = 4,
   parameter int CW   = 8,
   parameter     TYPE = "SOFT"
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            vddio_ok,
   input  logic            vdd_ok,
   input  logic            force_poc,
   input  logic [CW-1:0]   debounce,
   input  logic [CW-1:0]   step,
   output logic [NSEG-1:0] poc,
   output logic            ready,
   output logic [1:0]      state,
   output logic [7:0]      fault_cnt
);

   localparam int IW = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam logic [IW-1:0] LAST_SEG = IW'(NSEG - 1);

   typedef enum logic [1:0] {
      ST_OFF      = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_RELEASE  = 2'd2,
      ST_ON       = 2'd3
   } state_t;

   state_t          state_q;
   logic [NSEG-1:0] poc_q;
   logic            ready_q;
   logic [7:0]      fault_cnt_q;
   logic [CW-1:0]   cnt_q;
   logic [IW-1:0]   idx_q;

   logic            vddio_sync;
   logic            vdd_sync;
   logic            ok;

   // Two-flop synchronisers for both supply-good flags. The technology
   // branch is the place a library synchroniser cell goes; behaviour is the
   // same as the soft flops.
   if (TYPE == "SOFT") begin : g_sync_soft
      logic vddio_meta_q, vddio_sync_q;
      logic vdd_meta_q,   vdd_sync_q;

      // Soft synchroniser chain, cleared by reset.
      always_ff @(posedge clk) begin
         if (reset) begin
            vddio_meta_q <= 1'b0;
            vddio_sync_q <= 1'b0;
            vdd_meta_q   <= 1'b0;
            vdd_sync_q   <= 1'b0;
         end else begin
            vddio_meta_q <= vddio_ok;
            vddio_sync_q <= vddio_meta_q;
            vdd_meta_q   <= vdd_ok;
            vdd_sync_q   <= vdd_meta_q;
         end
      end

      assign vddio_sync = vddio_sync_q;
      assign vdd_sync   = vdd_sync_q;
   end else begin : g_sync_tech
      logic [1:0] meta_q;
      logic [1:0] sync_q;

      // Paired synchroniser stages for the technology variant.
      always_ff @(posedge clk) begin
         if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
         end else begin
            meta_q <= {vddio_ok, vdd_ok};
            sync_q <= meta_q;
         end
      end

      assign vddio_sync = sync_q[1];
      assign vdd_sync   = sync_q[0];
   end

   assign ok = vddio_sync & vdd_sync;

   // Sequencer: reset, then supply loss, then software force, then the
   // normal OFF -> DEBOUNCE -> RELEASE -> ON progression.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_OFF;
         poc_q       <= '1;
         ready_q     <= 1'b0;
         fault_cnt_q <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
      end else if ((state_q != ST_OFF) && (!ok || force_poc)) begin
         // Supply loss outranks force; only a loss after release began is a fault.
         if (!ok && ((state_q == ST_RELEASE) || (state_q == ST_ON)) &&
             (fault_cnt_q != 8'hFF)) begin
            fault_cnt_q <= fault_cnt_q + 8'd1;
         end
         state_q <= ST_OFF;
         poc_q   <= '1;
         ready_q <= 1'b0;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               poc_q   <= '1;
               ready_q <= 1'b0;
               cnt_q   <= '0;
               idx_q   <= '0;
               if (ok && !force_poc) begin
                  state_q <= ST_DEBOUNCE;
               end
            end
            ST_DEBOUNCE: begin
               // Equality compare only: a threshold lowered below cnt wraps first.
               if (cnt_q == debounce) begin
                  state_q <= ST_RELEASE;
                  cnt_q   <= '0;
                  idx_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_RELEASE: begin
               if (cnt_q == step) begin
                  poc_q[idx_q] <= 1'b0;
                  cnt_q        <= '0;
                  idx_q        <= idx_q + IW'(1);
                  if (idx_q == LAST_SEG) begin
                     state_q <= ST_ON;
                     ready_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_ON: begin
               poc_q   <= '0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= ST_OFF;
            end
         endcase
      end
   end

   assign poc       = poc_q;
   assign ready     = ready_q;
   assign state     = state_q;
   assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_asic_iocorner_poc.sv
// Self-checking bench for asic_iocorner_poc: a timeline-based reference model
// (release times computed from the DEBOUNCE entry edge) checked every cycle,
// plus directed literal checks that pin the model.
module tb_asic_iocorner_poc;

   localparam int NSEG = 4;
   localparam int CW   = 8;

   logic            clk       = 1'b0;
   logic            reset     = 1'b1;
   logic            vddio_ok  = 1'b0;
   logic            vdd_ok    = 1'b0;
   logic            force_poc = 1'b0;
   logic [CW-1:0]   debounce  = 8'd4;
   logic [CW-1:0]   step      = 8'd2;
   logic [NSEG-1:0] poc;
   logic            ready;
   logic [1:0]      state;
   logic [7:0]      fault_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   asic_iocorner_poc #(.NSEG(NSEG), .CW(CW), .TYPE("SOFT")) dut (
      .clk       (clk),
      .reset     (reset),
      .vddio_ok  (vddio_ok),
      .vdd_ok    (vdd_ok),
      .force_poc (force_poc),
      .debounce  (debounce),
      .step      (step),
      .poc       (poc),
      .ready     (ready),
      .state     (state),
      .fault_cnt (fault_cnt)
   );

   // ---------------- reference model ----------------
   // A sequence is described by the edge it entered DEBOUNCE (m_t0) and the
   // config latched then; every later phase is derived arithmetically.
   bit       m_active = 1'b0;
   longint   m_t0     = 0;
   longint   m_n      = 1;       // number of the next rising edge
   int       m_dbc    = 0;
   int       m_stp    = 0;
   int       m_fault  = 0;
   bit [1:0] m_vio    = '0;      // [0] sampled last edge, [1] the edge before
   bit [1:0] m_vdd    = '0;
   bit       m_check  = 1'b0;

   // Phase after edge n: 0 OFF, 1 DEBOUNCE, 2 RELEASE, 3 ON.
   function automatic int phase_after(longint n);
      longint rel, on_e;
      if (!m_active) return 0;
      rel  = m_t0 + m_dbc + 1;
      on_e = rel + NSEG * (m_stp + 1);
      if (n < rel)  return 1;
      if (n < on_e) return 2;
      return 3;
   endfunction

   function automatic logic [NSEG-1:0] exp_poc(longint n);
      int              ph;
      logic [NSEG-1:0] m;
      longint          rel;
      ph = phase_after(n);
      m  = '1;
      if (ph == 3) return '0;
      if (ph == 2) begin
         rel = m_t0 + m_dbc + 1;
         return m << ((n - rel) / (m_stp + 1));
      end
      return m;
   endfunction

   // Model update on each rising edge.
   always @(posedge clk) begin
      m_n <= m_n + 1;
      if (reset) begin
         m_active <= 1'b0;
         m_fault  <= 0;
         m_vio    <= '0;
         m_vdd    <= '0;
      end else begin
         m_vio <= {m_vio[0], vddio_ok};
         m_vdd <= {m_vdd[0], vdd_ok};
         if (phase_after(m_n - 1) != 0 && !(m_vio[1] & m_vdd[1])) begin
            m_active <= 1'b0;
            if (phase_after(m_n - 1) >= 2 && m_fault < 255) m_fault <= m_fault + 1;
         end else if (phase_after(m_n - 1) != 0 && force_poc) begin
            m_active <= 1'b0;
         end else if (phase_after(m_n - 1) == 0 && (m_vio[1] & m_vdd[1]) && !force_poc) begin
            m_active <= 1'b1;
            m_t0     <= m_n;
            m_dbc    <= int'(debounce);
            m_stp    <= int'(step);
         end
      end
   end

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      if (m_check) begin
         tests++;
         if (poc !== exp_poc(m_n - 1) || ready !== 1'(phase_after(m_n - 1) == 3) ||
             state !== 2'(phase_after(m_n - 1)) || fault_cnt !== 8'(m_fault)) begin
            fails++;
            $display("FAIL model edge %0d: poc=%b ready=%b state=%0d fault=%0d, required poc=%b ready=%b state=%0d fault=%0d",
                     m_n - 1, poc, ready, state, fault_cnt, exp_poc(m_n - 1),
                     phase_after(m_n - 1) == 3, phase_after(m_n - 1), m_fault);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic wait_state(input logic [1:0] s, input int lim, input string nm);
      int k = 0;
      while (state !== s && k < lim) begin @(negedge clk); k++; end
      chk(nm, longint'(state), longint'(s));
   endtask

   task automatic wait_poc(input logic [NSEG-1:0] p, input int lim, input string nm);
      int k = 0;
      while (poc !== p && k < lim) begin @(negedge clk); k++; end
      chk(nm, longint'(poc), longint'(p));
   endtask

   task automatic wait_ready(input int lim, input string nm);
      int k = 0;
      while (ready !== 1'b1 && k < lim) begin @(negedge clk); k++; end
      chk(nm, longint'(ready), 1);
   endtask

   // Config changes happen only under force, so the FSM is parked in OFF.
   task automatic set_cfg(input int d, input int s);
      force_poc = 1'b1;
      debounce  = CW'(d);
      step      = CW'(s);
      @(negedge clk);
      @(negedge clk);
      force_poc = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      int k, f0, r, fhold;
      fhold = 0;

      repeat (3) @(negedge clk);
      m_check = 1'b1;
      chk("reset poc", longint'(poc), 'hF);
      chk("reset ready", longint'(ready), 0);
      chk("reset state", longint'(state), 0);
      chk("reset fault", longint'(fault_cnt), 0);

      // 1: debounce=4, step=2, both supplies rise at edge t.
      reset = 1'b0; vddio_ok = 1'b1; vdd_ok = 1'b1;
      for (int i = 0; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1)  chk("t1 state t+1", longint'(state), 0);
         if (i == 2)  chk("t1 state t+2", longint'(state), 1);
         if (i == 6)  chk("t1 state t+6", longint'(state), 1);
         if (i == 7)  chk("t1 state t+7", longint'(state), 2);
         if (i == 9)  chk("t1 poc t+9", longint'(poc), 'hF);
         if (i == 10) chk("t1 poc t+10", longint'(poc), 'hE);
         if (i == 13) chk("t1 poc t+13", longint'(poc), 'hC);
         if (i == 16) chk("t1 poc t+16", longint'(poc), 'h8);
         if (i == 18) chk("t1 ready t+18", longint'(ready), 0);
         if (i == 19) chk("t1 poc t+19", longint'(poc), 'h0);
         if (i == 19) chk("t1 ready t+19", longint'(ready), 1);
      end

      // 2: debounce=0, step=0; release re-timed from reset deassertion.
      reset = 1'b1; debounce = '0; step = '0;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         if (i == 2) chk("t2 state t+2", longint'(state), 1);
         if (i == 3) chk("t2 poc t+3", longint'(poc), 'hF);
         if (i == 4) chk("t2 poc t+4", longint'(poc), 'hE);
         if (i == 5) chk("t2 poc t+5", longint'(poc), 'hC);
         if (i == 6) chk("t2 ready t+6", longint'(ready), 0);
         if (i == 7) chk("t2 poc t+7", longint'(poc), 'h0);
         if (i == 7) chk("t2 ready t+7", longint'(ready), 1);
      end

      // 3: drop vdd_ok in ON.
      vdd_ok = 1'b0;
      for (int i = 0; i <= 2; i++) begin
         @(negedge clk);
         if (i == 1) chk("t3 still on t+1", longint'(state), 3);
         if (i == 2) begin
            chk("t3 poc t+2", longint'(poc), 'hF);
            chk("t3 ready t+2", longint'(ready), 0);
            chk("t3 state t+2", longint'(state), 0);
            chk("t3 fault t+2", longint'(fault_cnt), 1);
         end
      end
      vdd_ok = 1'b1;
      wait_ready(50, "t3 rerun ready");

      // 4: vddio_ok glitch during DEBOUNCE.
      set_cfg(10, 1);
      wait_state(2'd1, 20, "t4 enter debounce");
      repeat (3) @(negedge clk);
      vddio_ok = 1'b0;
      @(negedge clk);
      vddio_ok = 1'b1;
      wait_state(2'd0, 10, "t4 glitch to off");
      chk("t4 fault unchanged", longint'(fault_cnt), 1);
      wait_state(2'd1, 10, "t4 reenter debounce");
      k = 0;
      while (state !== 2'd2 && k < 40) begin @(negedge clk); k++; end
      chk("t4 debounce restart length", k, 11);

      // 5: force_poc mid-RELEASE.
      set_cfg(4, 2);
      wait_poc(4'b1100, 60, "t5 reach 1100");
      f0 = fault_cnt;
      force_poc = 1'b1;
      @(negedge clk);
      chk("t5 poc", longint'(poc), 'hF);
      chk("t5 state", longint'(state), 0);
      chk("t5 fault", longint'(fault_cnt), f0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("t5 held off", longint'(state), 0);
      end
      force_poc = 1'b0;

      // Randomised supply, force and reset activity.
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         r = $urandom_range(0, 999);
         if (reset) begin
            reset = 1'b0;
         end else if (force_poc) begin
            if (fhold == 0) force_poc = 1'b0;
            else fhold--;
         end else if (r < 8) begin
            force_poc = 1'b1;
            fhold     = $urandom_range(0, 4);
            debounce  = CW'($urandom_range(0, 6));
            step      = CW'($urandom_range(0, 6));
         end else if (r < 10) begin
            reset    = 1'b1;
            debounce = CW'($urandom_range(0, 6));
            step     = CW'($urandom_range(0, 6));
         end
         if (vddio_ok) begin if ($urandom_range(0, 999) < 15) vddio_ok = 1'b0; end
         else if ($urandom_range(0, 999) < 300) vddio_ok = 1'b1;
         if (vdd_ok) begin if ($urandom_range(0, 999) < 15) vdd_ok = 1'b0; end
         else if ($urandom_range(0, 999) < 300) vdd_ok = 1'b1;
      end
      force_poc = 1'b0; reset = 1'b0; vddio_ok = 1'b1; vdd_ok = 1'b1;

      // 6: 260 supply losses in ON saturate the fault counter.
      reset = 1'b1; debounce = '0; step = '0;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      for (int e = 0; e < 260; e++) begin
         wait_ready(40, "t6 ready before loss");
         vdd_ok = 1'b0;
         repeat (3) @(negedge clk);
         vdd_ok = 1'b1;
         if (e == 99)  chk("t6 fault after 100", longint'(fault_cnt), 100);
         if (e == 254) chk("t6 fault after 255", longint'(fault_cnt), 255);
         if (e == 259) chk("t6 fault saturated", longint'(fault_cnt), 255);
      end

      // Synchronous reset mid-RELEASE.
      set_cfg(0, 3);
      wait_poc(4'b1110, 60, "t6 reach 1110");
      reset = 1'b1;
      @(negedge clk);
      chk("t6 reset poc", longint'(poc), 'hF);
      chk("t6 reset ready", longint'(ready), 0);
      chk("t6 reset state", longint'(state), 0);
      chk("t6 reset fault", longint'(fault_cnt), 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/asic_iocorner_poc.md
Name: asic_iocorner_poc

Overview:
- Parametrised power-on-control (POC) sequencer for the IO ring. It generalises the passive corner cell, which only feeds poc, vddio, vdd and vss through, into an active per-segment controller.
- It synchronises and debounces the supply-good indications.
- It then releases POC to NSEG ring segments one at a time, with a programmable stagger, to limit IO inrush current.
- On loss of supply it re-asserts all POC immediately and counts the faults.
- One instance sits at a ring corner and drives the poc feed-through of each segment.

Parameters:
- NSEG, 4, number of ring segments with independent poc outputs (1..16).
- CW, 8, width of the debounce and step counters/config.
- TYPE, "SOFT", implementation type: "SOFT" or a private technology variant. Behaviour is identical for both.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- vddio_ok  input  1  IO supply good, asynchronous to clk.
- vdd_ok  input  1  core supply good, asynchronous to clk.
- force_poc  input  1  software request to hold IOs safe (synchronous).
- debounce  input  CW  number of extra stable cycles required in DEBOUNCE.
- step  input  CW  extra cycles between successive segment releases.
- poc  output  NSEG  per-segment POC; 1 means IOs held in safe state.
- ready  output  1  all segments released, ring operational.
- state  output  2  FSM state: OFF=0, DEBOUNCE=1, RELEASE=2, ON=3.
- fault_cnt  output  8  saturating count of supply losses in RELEASE/ON.

Behaviour:
- Clock and reset:
  - One clock (clk).
  - reset is synchronous and active-high. It is sampled only on the rising edge of clk and has highest priority.
- Reset values:
  - poc = all 1s, ready = 0, state = OFF, fault_cnt = 0.
  - Synchroniser flops = 0, counters and segment index = 0.
- Synchronisers:
  - vddio_ok and vdd_ok each pass through a 2-flop synchroniser.
  - ok = sync(vddio_ok) & sync(vdd_ok).
  - An input sampled high at edge t gives ok = 1 after edge t+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Priority per edge: reset > (!ok while state != OFF) > force_poc > normal transitions.
- OFF:
  - poc = all 1s, ready = 0, cnt = 0, idx = 0.
  - If ok & !force_poc, go to DEBOUNCE with cnt = 0.
- DEBOUNCE:
  - If cnt == debounce, go to RELEASE with cnt = 0 and idx = 0.
  - Otherwise cnt++.
  - debounce = 0 means a single cycle in DEBOUNCE.
- RELEASE:
  - If cnt == step: clear poc[idx], set cnt = 0, idx++.
  - Otherwise cnt++.
  - When idx == NSEG-1 is cleared, move to ON and set ready = 1 on the same edge.
  - Segment k is released exactly (k+1)*(step+1) edges after RELEASE entry.
  - Release order is poc[0] first, ascending.
- ON:
  - poc = 0, ready = 1.
  - Stay in ON until a supply loss or force_poc.
- Supply loss (!ok in DEBOUNCE, RELEASE or ON):
  - Next edge: state = OFF, poc = all 1s, ready = 0.
  - fault_cnt increments, saturating at 255, only if the state was RELEASE or ON.
  - Loss during DEBOUNCE returns to OFF without counting a fault.
- force_poc in any non-OFF state:
  - Next edge: state = OFF, poc = all 1s, ready = 0.
  - No fault count.
  - While force_poc stays high, the FSM remains in OFF.
- Mid-operation changes:
  - A change to debounce or step mid-count takes effect at the next comparison. Comparisons are equality only.
  - Software must hold debounce and step stable during DEBOUNCE and RELEASE.
  - If a value is lowered below the current cnt, cnt wraps at 2^CW before matching. This is documented behaviour, not an error.
- fault_cnt clears only on reset.
- Reset asserted mid-RELEASE returns every output to its reset value on that edge.

Test Plan:
1. Reset, then NSEG=4, debounce=4, step=2; raise both ok at edge t. Required:
   - state = DEBOUNCE after t+2 and RELEASE after t+7.
   - poc = 1110, 1100, 1000, 0000 after t+10, t+13, t+16, t+19.
   - ready = 1 after t+19.
2. debounce=0, step=0, with both ok held high. Required: poc clears one bit per cycle on 4 consecutive edges after RELEASE entry, and ready asserts with the last bit.
3. In ON, drop vdd_ok at edge t. Required: poc = 1111, ready = 0, state = OFF and fault_cnt = 1 after t+2. Restoring vdd_ok re-runs the full sequence.
4. Glitch vddio_ok low during DEBOUNCE. Required: return to OFF, fault_cnt unchanged, and the debounce count restarts from 0 on re-entry.
5. Assert force_poc mid-RELEASE (poc = 1100). Required: next edge gives poc = 1111, state = OFF and fault_cnt unchanged. Holding force_poc high for 20 cycles keeps state OFF.
6. Produce 260 supply-loss events while in ON. Required: fault_cnt saturates at 255. Synchronous reset mid-RELEASE returns poc = 1111, ready = 0, fault_cnt = 0.
